// File: rtl/apb_2_lint_pkg.sv
// apb_2_lint_pkg: shared types and constants for the APB-to-lint bridge.
//   state_t                : bridge FSM states (IDLE, REQ, WAIT, DONE)
//   ERR_RDATA              : read data returned on an aborted access
//   DEFAULT_TIMEOUT_CYCLES : default abort threshold (APB_2_LINT_TIMEOUT_EN builds)
package apb_2_lint_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/apb_2_lint.sv
// apb_2_lint: APB slave to lint master bridge. Each APB access phase is
// turned into exactly one lint transaction; PREADY pulses for one cycle
// once the lint response has arrived.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE APB request
//   PRDATA/PREADY/PSLVERR            APB response
//   data_req_o/add_o/wen_o/wdata_o/be_o, data_gnt_i   lint request
//   data_r_valid_i/data_r_rdata_i                     lint response
//
// Configuration:
//   APB_2_LINT_TIMEOUT_EN  when defined, an access that spends TIMEOUT_CYCLES
//                          cycles in REQ/WAIT is aborted with PSLVERR=1 and
//                          PRDATA=ERR_RDATA. Otherwise PSLVERR is tied low and
//                          the bridge waits indefinitely.
module apb_2_lint
  import apb_2_lint_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PWRITE,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  data_req_o,
  output logic [ADDR_WIDTH-1:0] data_add_o,
  output logic                  data_wen_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  output logic [BE_WIDTH-1:0]   data_be_o,
  input  logic                  data_gnt_i,
  input  logic                  data_r_valid_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i
);

  state_t state;
  logic   start;
  logic   finish;
  logic   abort;

  assign start  = (state == IDLE) && PSEL && PENABLE;
  // Normal progress wins over a timeout that expires in the same cycle.
  assign finish = ((state == REQ) && data_gnt_i) || ((state == WAIT) && data_r_valid_i);

`ifdef APB_2_LINT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             expired;

  // cnt holds the number of completed REQ/WAIT cycles, so the access is
  // abandoned at the end of its TIMEOUT_CYCLES-th cycle.
  assign expired = (32'(cnt) + 32'd1) >= TIMEOUT_CYCLES;
  assign abort   = ((state == REQ) || (state == WAIT)) && expired && !finish;
  assign PSLVERR = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (start) begin
        cnt <= '0;
      end else if ((state == REQ) || (state == WAIT)) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (abort) begin
        err <= 1'b1;
      end else if (state == DONE) begin
        err <= 1'b0;
      end
    end
  end
`else
  assign abort   = 1'b0;
  assign PSLVERR = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      data_add_o   <= '0;
      data_wen_o   <= 1'b0;
      data_wdata_o <= '0;
      PRDATA       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            data_add_o   <= {PADDR[ADDR_WIDTH-1:2], 2'b00};
            data_wen_o   <= PWRITE;
            data_wdata_o <= PWDATA;
            state        <= REQ;
          end
        end
        REQ: begin
          if (finish) begin
            state <= WAIT;
          end else if (abort) begin
            PRDATA <= DATA_WIDTH'(ERR_RDATA);
            state  <= DONE;
          end
        end
        WAIT: begin
          if (finish) begin
            PRDATA <= data_wen_o ? '0 : data_r_rdata_i;
            state  <= DONE;
          end else if (abort) begin
            PRDATA <= DATA_WIDTH'(ERR_RDATA);
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign data_req_o = (state == REQ);
  assign PREADY     = (state == DONE);
  assign data_be_o  = '1;

  // The lint side is word addressed; the byte offset of PADDR is dropped.
  logic unused_ok;
  assign unused_ok = ^{PADDR[1:0], 32'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_apb_2_lint.sv
// tb_apb_2_lint: randomized self-checking bench for apb_2_lint. Each APB
// access is described by its grant delay g and response delay r; the
// expected cycle-by-cycle behaviour is derived from those numbers.
module tb_apb_2_lint;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int          T  = 8;
`ifdef APB_2_LINT_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0;
  logic          PWRITE = 1'b0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic          data_req_o;
  logic [AW-1:0] data_add_o;
  logic          data_wen_o;
  logic [DW-1:0] data_wdata_o;
  logic [BW-1:0] data_be_o;
  logic          data_gnt_i = 1'b0;
  logic          data_r_valid_i = 1'b0;
  logic [DW-1:0] data_r_rdata_i = '0;

  apb_2_lint #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PADDR         (PADDR),
    .PWDATA        (PWDATA),
    .PWRITE        (PWRITE),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR),
    .data_req_o    (data_req_o),
    .data_add_o    (data_add_o),
    .data_wen_o    (data_wen_o),
    .data_wdata_o  (data_wdata_o),
    .data_be_o     (data_be_o),
    .data_gnt_i    (data_gnt_i),
    .data_r_valid_i(data_r_valid_i),
    .data_r_rdata_i(data_r_rdata_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int grants   = 0;
  int readies  = 0;
  logic [DW-1:0] exp_prdata = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshake / response pulse counters.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_req_o && data_gnt_i) grants++;
      if (PREADY) readies++;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      PADDR = $urandom; PWDATA = $urandom; PWRITE = 1'($urandom_range(1));
      data_gnt_i = 1'($urandom_range(1));
      data_r_valid_i = 1'($urandom_range(1));
      data_r_rdata_i = $urandom;
      @(negedge clk);
      chk("idle_pready", 64'(PREADY), 64'(0));
      chk("idle_req", 64'(data_req_o), 64'(0));
      chk("idle_prdata_hold", 64'(PRDATA), 64'(exp_prdata));
      chk("idle_pslverr", 64'(PSLVERR), 64'(0));
    end
  endtask

  // One APB transfer: setup phase, then access cycles k=1..last.
  // Grant arrives in access cycle 2+g, response in access cycle 2+g+r.
  task automatic xfer(input logic wr, input int g, input int r, input bit stray,
                      input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [DW-1:0] rd);
    logic [AW-1:0] exp_add;
    bit            to;
    bit            exp_req;
    int            last;
    exp_add = {a[AW-1:2], 2'b00};
    to   = TO_ON && (g + 1 + r > T);
    last = to ? 2 + T : 3 + g + r;

    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = wd; PWRITE = wr;
    data_gnt_i = 1'b0;
    data_r_valid_i = stray ? 1'($urandom_range(1)) : 1'b0;
    data_r_rdata_i = $urandom;
    @(negedge clk);
    chk("setup_pready", 64'(PREADY), 64'(0));
    chk("setup_req", 64'(data_req_o), 64'(0));

    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      PENABLE = 1'b1;
      data_gnt_i = (k == 2 + g);
      if (k == 2 + g + r) begin
        data_r_valid_i = 1'b1;
        data_r_rdata_i = rd;
      end else begin
        data_r_valid_i = stray && (k == 1 || k == last || (k <= 2 + g && k <= 1 + T))
                         ? 1'($urandom_range(1)) : 1'b0;
        data_r_rdata_i = $urandom;
      end
      @(negedge clk);
      exp_req = (k >= 2) && (k <= 2 + g) && (!TO_ON || k <= 1 + T);
      chk("req", 64'(data_req_o), 64'(exp_req));
      if (exp_req) begin
        chk("add", 64'(data_add_o), 64'(exp_add));
        chk("wen", 64'(data_wen_o), 64'(wr));
        chk("wdata", 64'(data_wdata_o), 64'(wd));
        chk("be", 64'(data_be_o), 64'({BW{1'b1}}));
      end
      chk("pready", 64'(PREADY), 64'(k == last));
      if (k == last) begin
        exp_prdata = to ? 32'hDEAD_BEEF : (wr ? '0 : rd);
        chk("prdata", 64'(PRDATA), 64'(exp_prdata));
        chk("pslverr", 64'(PSLVERR), 64'(to));
      end else begin
        chk("pslverr_low", 64'(PSLVERR), 64'(0));
      end
    end
  endtask

  task automatic reset_in_wait();
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = $urandom; PWDATA = $urandom; PWRITE = 1'b0;
    data_gnt_i = 1'b0; data_r_valid_i = 1'b0;
    @(posedge clk); #1; PENABLE = 1'b1;
    @(posedge clk); #1; data_gnt_i = 1'b1;
    @(negedge clk);
    chk("rst_req_before", 64'(data_req_o), 64'(1));
    @(posedge clk); #1; data_gnt_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", 64'(data_req_o), 64'(0));
    chk("rst_pready", 64'(PREADY), 64'(0));
    chk("rst_prdata", 64'(PRDATA), 64'(0));
    chk("rst_add", 64'(data_add_o), 64'(0));
    exp_prdata = '0;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    idle(3);
  endtask

  int g0, r0;

  initial begin
    #1;
    chk("reset_req", 64'(data_req_o), 64'(0));
    chk("reset_wen", 64'(data_wen_o), 64'(0));
    chk("reset_add", 64'(data_add_o), 64'(0));
    chk("reset_wdata", 64'(data_wdata_o), 64'(0));
    chk("reset_be", 64'(data_be_o), 64'({BW{1'b1}}));
    chk("reset_prdata", 64'(PRDATA), 64'(0));
    chk("reset_pready", 64'(PREADY), 64'(0));
    chk("reset_pslverr", 64'(PSLVERR), 64'(0));
    #21 rst_n = 1'b1;
    idle(2);

    // Directed read: grant same cycle, response next cycle.
    xfer(1'b0, 0, 1, 1'b0, 32'h1A10_1006, $urandom, 32'h1029_3847);
    idle(2);
    // Directed write: grant delayed 3 cycles.
    xfer(1'b1, 3, 1, 1'b0, $urandom, 32'hA5A5_0F0F, $urandom);
    idle(2);
    // Stray response pulses in IDLE and REQ.
    xfer(1'b0, 3, 2, 1'b1, $urandom, $urandom, $urandom);
    idle(2);
    // Abandoned access, then a normal read.
    reset_in_wait();
    xfer(1'b0, 0, 1, 1'b0, $urandom, $urandom, $urandom);
    idle(1);
    // Grant withheld: aborts after T cycles when enabled, else keeps waiting.
    xfer(1'b0, 20, 1, 1'b0, $urandom, $urandom, $urandom);
    idle(3);
    // Back-to-back reads separated only by a setup phase.
    g0 = grants; r0 = readies;
    xfer(1'b0, 0, 1, 1'b0, $urandom, $urandom, $urandom);
    xfer(1'b0, 1, 2, 1'b0, $urandom, $urandom, $urandom);
    idle(1);
    chk("b2b_grants", 64'(grants - g0), 64'(2));
    chk("b2b_readies", 64'(readies - r0), 64'(2));

    repeat (40) begin
      xfer(1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(3, 1)),
           1'b1, $urandom, $urandom, $urandom);
      idle(int'($urandom_range(2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
